// File: rtl/seq_pkg.sv
// Shared types for the sequence-detector slice: serializer state encoding
// and the default serial word length.
package seq_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  localparam int SEQ_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, out MSB-first
// on x, one bit per clock, with a one-word holding register for gapless streaming.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_t       state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             hold_full, hold_full_n;
  logic             accept;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state     <= IDLE;
      sreg      <= '0;
      hold      <= '0;
      cnt       <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      hold      <= hold_n;
      cnt       <= cnt_n;
      hold_full <= hold_full_n;
    end
  end

  assign accept = din_valid & din_ready;

  // On the last bit a held word takes priority; only with hold empty can a
  // freshly offered word bypass straight into the shift register.
  always_comb begin
    state_n     = state;
    sreg_n      = sreg;
    hold_n      = hold;
    cnt_n       = cnt;
    hold_full_n = hold_full;
    unique case (state)
      IDLE: begin
        if (accept) begin
          sreg_n  = din;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != LAST) begin
          sreg_n = sreg << 1;
          cnt_n  = cnt + CW'(1);
          if (accept) begin
            hold_n      = din;
            hold_full_n = 1'b1;
          end
        end else if (hold_full) begin
          sreg_n      = hold;
          hold_full_n = 1'b0;
          cnt_n       = '0;
        end else if (accept) begin
          sreg_n = din;
          cnt_n  = '0;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Detectors sample x every clock, so it must read 0 outside a word.
  assign x         = (state == SHIFT) & sreg[WIDTH-1];
  assign x_valid   = (state == SHIFT);
  assign din_ready = ~hold_full;
  assign busy      = (state == SHIFT) | hold_full;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: per-cycle vector table on an 8-bit
// instance plus a hand-written streaming sequence on a 4-bit instance.
module tb_seq_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear;
  logic [7:0] din;
  logic       din_valid, din_ready, x, x_valid, busy;

  logic [3:0] din4;
  logic       din4_valid, din4_ready, x4, x4_valid, busy4;

  seq_serializer #(.WIDTH(8)) dut8 (
    .clk(clk), .clear(clear), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .x(x), .x_valid(x_valid), .busy(busy)
  );

  seq_serializer #(.WIDTH(4)) dut4 (
    .clk(clk), .clear(clear), .din(din4), .din_valid(din4_valid),
    .din_ready(din4_ready), .x(x4), .x_valid(x4_valid), .busy(busy4)
  );

  typedef struct {
    logic       clear;
    logic [7:0] din;
    logic       din_valid;
    logic       x;
    logic       x_valid;
    logic       din_ready;
    logic       busy;
  } vec_t;

  vec_t vecs[$];
  int testsRun = 0;
  int testsFailed = 0;

  task automatic addVec(input logic c, input logic [7:0] d, input logic v,
                        input logic ex, input logic exv, input logic erdy, input logic ebusy);
    vec_t t;
    t.clear = c; t.din = d; t.din_valid = v;
    t.x = ex; t.x_valid = exv; t.din_ready = erdy; t.busy = ebusy;
    vecs.push_back(t);
  endtask

  task automatic checkOutput(input string name, input int step, input logic act, input logic exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s step %0d: got %b, expected %b", name, step, act, exp);
    end
  endtask

  // Each vector is one clock cycle: inputs presented for the coming edge and
  // the outputs expected during that same cycle.
  task automatic applyStimulus(input logic c, input logic [7:0] d, input logic v);
    @(negedge clk);
    clear     = c;
    din       = d;
    din_valid = v;
    #1;
  endtask

  initial begin
    logic [7:0]  pat8;
    logic [15:0] pat16;

    clear      = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    din4       = '0;
    din4_valid = 1'b0;

    // reset held two cycles, then released with nothing offered
    addVec(0, 8'h00, 0, 0, 0, 1, 0);
    addVec(0, 8'h00, 0, 0, 0, 1, 0);
    addVec(1, 8'h00, 0, 0, 0, 1, 0);
    addVec(1, 8'hFF, 0, 0, 0, 1, 0);

    // single word 1001_1001 from IDLE
    pat8 = 8'b1001_1001;
    addVec(1, 8'h99, 1, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) addVec(1, 8'h00, 0, pat8[7-i], 1, 1, 1);
    addVec(1, 8'hFF, 0, 0, 0, 1, 0);

    // back-to-back A5 then 3C; E7 offered while hold is full must be dropped
    pat16 = 16'b1010_0101_0011_1100;
    addVec(1, 8'hA5, 1, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 0)     addVec(1, 8'h3C, 1, pat16[15-i], 1, 1, 1);
      else if (i < 8) addVec(1, 8'hE7, 1, pat16[15-i], 1, 0, 1);
      else            addVec(1, 8'h00, 0, pat16[15-i], 1, 1, 1);
    end
    addVec(1, 8'h00, 0, 0, 0, 1, 0);

    // last-bit bypass: F0 offered only during 55's final bit
    pat16 = 16'b0101_0101_1111_0000;
    addVec(1, 8'h55, 1, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 7) addVec(1, 8'hF0, 1, pat16[15-i], 1, 1, 1);
      else        addVec(1, 8'h00, 0, pat16[15-i], 1, 1, 1);
    end
    addVec(1, 8'h00, 0, 0, 0, 1, 0);

    // mid-word reset after three bits of FF with 81 held
    addVec(1, 8'hFF, 1, 0, 0, 1, 0);
    addVec(1, 8'h81, 1, 1, 1, 1, 1);
    addVec(1, 8'h00, 0, 1, 1, 0, 1);
    addVec(1, 8'h00, 0, 1, 1, 0, 1);
    addVec(0, 8'h00, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) addVec(1, 8'h00, 0, 0, 0, 1, 0);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].clear, vecs[k].din, vecs[k].din_valid);
      checkOutput("x",         k, x,         vecs[k].x);
      checkOutput("x_valid",   k, x_valid,   vecs[k].x_valid);
      checkOutput("din_ready", k, din_ready, vecs[k].din_ready);
      checkOutput("busy",      k, busy,      vecs[k].busy);
    end
    applyStimulus(1, 8'h00, 0);

    // WIDTH=4: C then 3 streamed through hold, reload wraps cnt with no gap
    pat8 = 8'b1100_0011;
    @(negedge clk); din4 = 4'hC; din4_valid = 1'b1; #1;
    checkOutput("w4_x",       100, x4,         1'b0);
    checkOutput("w4_x_valid", 100, x4_valid,   1'b0);
    checkOutput("w4_ready",   100, din4_ready, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin din4 = 4'h3; din4_valid = 1'b1; end
      else        begin din4 = 4'hF; din4_valid = 1'b0; end
      #1;
      checkOutput("w4_x",       100 + k, x4,         pat8[8-k]);
      checkOutput("w4_x_valid", 100 + k, x4_valid,   1'b1);
      checkOutput("w4_ready",   100 + k, din4_ready, (k >= 2 && k <= 4) ? 1'b0 : 1'b1);
      checkOutput("w4_busy",    100 + k, busy4,      1'b1);
    end
    @(negedge clk); #1;
    checkOutput("w4_x",       109, x4,         1'b0);
    checkOutput("w4_x_valid", 109, x4_valid,   1'b0);
    checkOutput("w4_busy",    109, busy4,      1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
